serial_alu_multiword: RTL and testbench
=======================================

// Module: serial_alu_multiword
// PURPOSE
//  Second-generation digit-serial ALU with an integrated scan register file.
//  Streams NSHIFT bits per cycle, LSB first, for ops spanning 1..MAX_WORDS chained registers (8/16/24/32-bit at defaults).
//  Adds a start/ready handshake, CMP/TEST (flags only), whole-op flags committed at completion, and reserved-op handling.
//  Sits between the instruction sequencer and the memory/data digit path.
// PARAMETERS
//  LOG2_NR   3  log2 of register count (NR = 2**LOG2_NR)
//  REG_BITS  8  bits per register; REG_BITS % NSHIFT == 0
//  NSHIFT    2  bits processed per cycle (digit width), >= 2
//  MAX_WORDS 4  max registers chained in one op; power of 2, <= NR
// PORTS
//  clk        in  1                 clock; all state on rising edge
//  reset_n    in  1                 asynchronous active-low reset
//  start      in  1                 request op; accepted when start && ready
//  ready      out 1                 block idle or in last RUN cycle
//  op         in  4                 0 ADD,1 SUB,2 ADC,3 SBC,4 AND,5 OR,6 XOR,7 MOV,8 CMP,9 TEST,10-15 reserved
//  reg1       in  LOG2_NR           dest / arg1 base register
//  reg2       in  LOG2_NR           arg2 base register (unused if ext_arg2)
//  num_words  in  clog2(MAX_WORDS)  word count minus 1
//  ext_arg2   in  1                 arg2 digits come from data_in instead of reg2
//  data_in    in  NSHIFT            external arg2 digit, sampled every RUN cycle
//  data_out   out NSHIFT            result digit of current cycle
//  data_valid out 1                 data_out valid (high throughout RUN)
//  done       out 1                 high in last RUN cycle
//  digit_idx  out clog2(MAX_WORDS*REG_BITS/NSHIFT)  current digit counter
//  flag_c/flag_v/flag_s/flag_z  out 1 each  status flags
// BEHAVIOUR
//  Reset: FSM=IDLE, counter=0, all registers=0, all flags=0, ready=1, done=0, data_valid=0, data_out=0.
//  FSM IDLE->RUN on accepted start; op, reg1, reg2, num_words, ext_arg2 latched at acceptance.
//  RUN lasts N=(num_words+1)*D cycles, D=REG_BITS/NSHIFT; counter 0..N-1; done=ready=1 on cycle N-1.
//  Last RUN cycle: start accepted -> RUN continues with new op, counter 0, no bubble; else -> IDLE.
//  start while busy (not last cycle) ignored, no side effects; new op sees updated flags.
//  Word w=counter/D: dest = (reg1+w) mod NR, src = (reg2+w) mod NR (wrap-around legal).
//  Each scanned register shifts right NSHIFT per cycle, new digit at MSB; full rotation per word restores alignment.
//  Registers not addressed in a cycle hold.
//  Operand reads use pre-cycle content; reg1==reg2 legal (read-before-write).
//  Arith: sum = a + (b ^ inv) + cin, inv=all-ones for SUB/SBC/CMP; carry chained across all digits and words.
//  cin at counter 0: ADD 0, SUB/CMP 1, ADC/SBC flag_c; afterwards internal carry.
//  Writeback: ADD..MOV only; CMP, TEST and reserved ops never write.
//  data_out = result digit for all ops (reserved ops output arg1).
//  Flags commit only at the edge ending cycle N-1, never mid-op:
//   C = carry out of MSB (SUB: 1 = no borrow)
//   V = signed overflow at MSB (arith ops; logic/MOV/TEST clear V, keep C)
//   S = result MSB; Z = every result digit of the whole op zero.
//  Reserved ops: run N cycles, no writeback, flags unchanged.
//  reset_n low at any time, including mid-op: immediate abort to reset state, partial results discarded.
// TESTING (REG_BITS=8, NSHIFT=2, D=4; loads via MOV ext_arg2, digits LSB first)
//  1 16-bit ADD: r0=FF,r1=00,r2=01,r3=00; ADD reg1=0 reg2=2 num_words=1 -> 8 cycles, r0=00,r1=01, C=0,Z=0,S=0,V=0.
//  2 SUB r4=00,r5=01 one word -> r4=FF, C=0,S=1,V=0; then ADD 7F+01 -> 80, V=1,S=1,C=0,Z=0.
//  3 CMP r6=55 vs r7=55 -> r6 unchanged, Z=1,C=1; reserved op 12 -> 4 cycles, flags and regs unchanged.
//  4 Back-to-back: start held, ADD r0+r2 then ADC r1+r3 -> no idle cycle between, ADC consumes C from ADD.
//  5 Wrap: reg1=7 num_words=1 -> dest r7 then r0; start pulsed mid-op -> ignored, ready=0.
//  6 reset_n low at counter=5 of 16-cycle op -> ready=1, flags=0, all regs=0 immediately.

Source files
------------

// File: rtl/serial_alu_multiword_if.sv
// Bus between the sequencer (master) and the serial ALU (slave).
// Carries the start/ready handshake, op fields, the digit path and the status flags.
interface serial_alu_multiword_if #(
   parameter int LOG2_NR   = 3,
   parameter int REG_BITS  = 8,
   parameter int NSHIFT    = 2,
   parameter int MAX_WORDS = 4
);
   localparam int NWW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam int DW  = $clog2(MAX_WORDS * REG_BITS / NSHIFT);

   logic               start;
   logic               ready;
   logic [3:0]         op;
   logic [LOG2_NR-1:0] reg1;
   logic [LOG2_NR-1:0] reg2;
   logic [NWW-1:0]     num_words;
   logic               ext_arg2;
   logic [NSHIFT-1:0]  data_in;
   logic [NSHIFT-1:0]  data_out;
   logic               data_valid;
   logic               done;
   logic [DW-1:0]      digit_idx;
   logic               flag_c;
   logic               flag_v;
   logic               flag_s;
   logic               flag_z;

   modport master (
      output start, op, reg1, reg2, num_words, ext_arg2, data_in,
      input  ready, data_out, data_valid, done, digit_idx,
      input  flag_c, flag_v, flag_s, flag_z
   );

   modport slave (
      input  start, op, reg1, reg2, num_words, ext_arg2, data_in,
      output ready, data_out, data_valid, done, digit_idx,
      output flag_c, flag_v, flag_s, flag_z
   );
endinterface

// File: rtl/serial_alu_multiword.sv
// Digit-serial ALU with scan register file; NSHIFT bits/cycle, LSB first, 1..MAX_WORDS words.
// Ports: clk, reset_n (async active-low), bus (slave: handshake, op fields, digit path, flags).
module serial_alu_multiword #(
   parameter int LOG2_NR   = 3,
   parameter int REG_BITS  = 8,
   parameter int NSHIFT    = 2,
   parameter int MAX_WORDS = 4
) (
   input logic                  clk,
   input logic                  reset_n,
   serial_alu_multiword_if.slave bus
);
   localparam int NR  = 2 ** LOG2_NR;
   localparam int D   = REG_BITS / NSHIFT;
   localparam int LD  = $clog2(D);
   localparam int NWW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam int CW  = $clog2(MAX_WORDS * D);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_ADC  = 4'd2;
   localparam logic [3:0] OP_SBC  = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_XOR  = 4'd6;
   localparam logic [3:0] OP_MOV  = 4'd7;
   localparam logic [3:0] OP_CMP  = 4'd8;
   localparam logic [3:0] OP_TEST = 4'd9;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t              r_state;
   state_t              w_state_nx;
   logic [CW-1:0]       r_cnt;
   logic [3:0]          r_op;
   logic [LOG2_NR-1:0]  r_reg1;
   logic [LOG2_NR-1:0]  r_reg2;
   logic [NWW-1:0]      r_nw;
   logic                r_ext;
   logic                r_carry;
   logic                r_zacc;
   logic [REG_BITS-1:0] r_rf [NR];
   logic                r_fc, r_fv, r_fs, r_fz;

   logic                w_run, w_last, w_ready, w_accept;
   logic [NWW-1:0]      w_word;
   logic [LOG2_NR-1:0]  w_dst, w_src;
   logic [NSHIFT-1:0]   w_a, w_rs, w_b, w_bx, w_res;
   logic                w_sub, w_arith, w_logic, w_wr, w_cin;
   logic [NSHIFT:0]     w_sum;
   logic                w_cout, w_cmsb, w_ovf, w_zall;

   assign w_run    = (r_state == S_RUN);
   assign w_word   = r_cnt[CW-1:LD];
   assign w_last   = w_run && (w_word == r_nw)
                   && (r_cnt[LD-1:0] == LD'(D - 1));
   assign w_ready  = !w_run || w_last;
   assign w_accept = bus.start && w_ready;

   // Word w of the op addresses reg1+w / reg2+w, wrapping mod NR.
   assign w_dst = r_reg1 + LOG2_NR'(w_word);
   assign w_src = r_reg2 + LOG2_NR'(w_word);
   assign w_a   = r_rf[w_dst][NSHIFT-1:0];
   assign w_rs  = r_rf[w_src][NSHIFT-1:0];
   assign w_b   = r_ext ? bus.data_in : w_rs;

   assign w_sub   = (r_op == OP_SUB) || (r_op == OP_SBC) || (r_op == OP_CMP);
   assign w_arith = (r_op <= OP_SBC) || (r_op == OP_CMP);
   assign w_logic = ((r_op >= OP_AND) && (r_op <= OP_MOV)) || (r_op == OP_TEST);
   assign w_wr    = (r_op <= OP_MOV);

   always_comb begin
      w_cin = r_carry;
      if (r_cnt == '0) begin
         unique case (1'b1)
            (r_op == OP_SUB) || (r_op == OP_CMP): w_cin = 1'b1;
            (r_op == OP_ADC) || (r_op == OP_SBC): w_cin = r_fc;
            default:                              w_cin = 1'b0;
         endcase
      end
   end

   assign w_bx   = w_b ^ {NSHIFT{w_sub}};
   assign w_sum  = {1'b0, w_a} + {1'b0, w_bx} + {{NSHIFT{1'b0}}, w_cin};
   assign w_cout = w_sum[NSHIFT];
   // Carry into the digit MSB recovered from the sum bit; V = cin(msb) ^ cout(msb).
   assign w_cmsb = w_a[NSHIFT-1] ^ w_bx[NSHIFT-1] ^ w_sum[NSHIFT-1];
   assign w_ovf  = w_cout ^ w_cmsb;

   always_comb begin
      w_res = w_a;
      unique case (1'b1)
         w_arith:                                w_res = w_sum[NSHIFT-1:0];
         (r_op == OP_AND) || (r_op == OP_TEST):  w_res = w_a & w_b;
         (r_op == OP_OR):                        w_res = w_a | w_b;
         (r_op == OP_XOR):                       w_res = w_a ^ w_b;
         (r_op == OP_MOV):                       w_res = w_b;
         default:                                w_res = w_a;
      endcase
   end

   assign w_zall = ((r_cnt == '0) ? 1'b1 : r_zacc) && (w_res == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         S_IDLE:  if (bus.start) w_state_nx = S_RUN;
         S_RUN:   if (w_last && !bus.start) w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      bus.ready      = w_ready;
      bus.done       = w_last;
      bus.data_valid = w_run;
      bus.data_out   = w_run ? w_res : '0;
   end

   assign bus.digit_idx = r_cnt;
   assign bus.flag_c    = r_fc;
   assign bus.flag_v    = r_fv;
   assign bus.flag_s    = r_fs;
   assign bus.flag_z    = r_fz;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_op    <= '0;
         r_reg1  <= '0;
         r_reg2  <= '0;
         r_nw    <= '0;
         r_ext   <= 1'b0;
         r_carry <= 1'b0;
         r_zacc  <= 1'b0;
         r_fc    <= 1'b0;
         r_fv    <= 1'b0;
         r_fs    <= 1'b0;
         r_fz    <= 1'b0;
         for (int i = 0; i < NR; i++) r_rf[i] <= '0;
      end else begin
         if (w_accept) begin
            r_op   <= bus.op;
            r_reg1 <= bus.reg1;
            r_reg2 <= bus.reg2;
            r_nw   <= bus.num_words;
            r_ext  <= bus.ext_arg2;
         end
         if (w_run) begin
            r_carry <= w_cout;
            r_zacc  <= w_zall;
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            // Source rotates; the dest write below wins when reg1==reg2.
            if (!r_ext)
               r_rf[w_src] <= {w_rs, r_rf[w_src][REG_BITS-1:NSHIFT]};
            r_rf[w_dst] <= {(w_wr ? w_res : w_a), r_rf[w_dst][REG_BITS-1:NSHIFT]};
            if (w_last) begin
               if (w_arith) begin
                  r_fc <= w_cout;
                  r_fv <= w_ovf;
                  r_fs <= w_res[NSHIFT-1];
                  r_fz <= w_zall;
               end else if (w_logic) begin
                  r_fv <= 1'b0;
                  r_fs <= w_res[NSHIFT-1];
                  r_fz <= w_zall;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_serial_alu_multiword.sv
// Directed bench for serial_alu_multiword (REG_BITS=8, NSHIFT=2, D=4).
// Registers are loaded with MOV ext_arg2 and read back with a reserved op.
module tb_serial_alu_multiword;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   int          total = 0;
   int          bad = 0;
   logic [31:0] d;
   bit          hs;

   serial_alu_multiword_if bus ();

   serial_alu_multiword dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not end");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] fl();
      return {bus.flag_c, bus.flag_v, bus.flag_s, bus.flag_z};
   endfunction

   task automatic go(input string tag, input logic [3:0] o, input logic [2:0] a,
                     input logic [2:0] b, input logic [1:0] nw, input logic ext,
                     input logic [31:0] din, output logic [31:0] dout);
      int n;
      bit ok;
      n = (int'(nw) + 1) * 4;
      ok = 1;
      dout = '0;
      @(negedge clk);
      if (bus.ready !== 1'b1) ok = 0;
      bus.start = 1'b1; bus.op = o; bus.reg1 = a; bus.reg2 = b;
      bus.num_words = nw; bus.ext_arg2 = ext; bus.data_in = din[1:0];
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus.data_in = din[2*i +: 2];
         @(negedge clk);
         dout[2*i +: 2] = bus.data_out;
         if (!(bus.data_valid === 1'b1 && bus.done === (i == n - 1)
               && bus.digit_idx === 4'(i))) ok = 0;
         @(posedge clk); #1;
      end
      if (tag != "") chk(tag, 32'(ok), 32'd1);
   endtask

   task automatic ld(input logic [2:0] r, input logic [7:0] v);
      logic [31:0] t;
      go("", 4'd7, r, 3'd0, 2'd0, 1'b1, {24'd0, v}, t);
   endtask

   task automatic rd(input logic [2:0] r, input logic [1:0] nw, output logic [31:0] v);
      go("", 4'd15, r, 3'd0, nw, 1'b0, 32'd0, v);
   endtask

   initial begin
      bus.start = 0; bus.op = 0; bus.reg1 = 0; bus.reg2 = 0;
      bus.num_words = 0; bus.ext_arg2 = 0; bus.data_in = 0;

      // reset state
      #12;
      chk("rst_ready", 32'(bus.ready), 32'd1);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_valid", 32'(bus.data_valid), 32'd0);
      chk("rst_dout", 32'(bus.data_out), 32'd0);
      chk("rst_flags", 32'(fl()), 32'd0);
      chk("rst_idx", 32'(bus.digit_idx), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // 16-bit ADD 00FF + 0001
      ld(0, 8'hFF); ld(1, 8'h00); ld(2, 8'h01); ld(3, 8'h00);
      go("add16_hs", 4'd0, 3'd0, 3'd2, 2'd1, 1'b0, 32'd0, d);
      chk("add16_out", d, 32'h0100);
      chk("add16_flags", 32'(fl()), 32'h0);
      rd(0, 2'd1, d);
      chk("add16_regs", d, 32'h0100);

      // SUB 00 - 01, then ADD 7F + 01
      ld(4, 8'h00); ld(5, 8'h01);
      go("sub_hs", 4'd1, 3'd4, 3'd5, 2'd0, 1'b0, 32'd0, d);
      chk("sub_out", d, 32'hFF);
      chk("sub_flags", 32'(fl()), 32'b0010);
      rd(4, 2'd0, d);
      chk("sub_reg", d, 32'hFF);
      ld(4, 8'h7F); ld(5, 8'h01);
      go("", 4'd0, 3'd4, 3'd5, 2'd0, 1'b0, 32'd0, d);
      chk("ovf_out", d, 32'h80);
      chk("ovf_flags", 32'(fl()), 32'b0110);

      // CMP equal, then reserved op
      ld(6, 8'h55); ld(7, 8'h55);
      go("", 4'd8, 3'd6, 3'd7, 2'd0, 1'b0, 32'd0, d);
      chk("cmp_out", d, 32'h00);
      chk("cmp_flags", 32'(fl()), 32'b1001);
      go("rsv_hs", 4'd12, 3'd6, 3'd0, 2'd0, 1'b0, 32'd0, d);
      chk("rsv_out", d, 32'h55);
      chk("rsv_flags", 32'(fl()), 32'b1001);
      rd(7, 2'd0, d);
      chk("cmp_src", d, 32'h55);

      // back-to-back ADD r0+r2 then ADC r1+r3, start held
      ld(0, 8'hFF); ld(1, 8'h00); ld(2, 8'h01); ld(3, 8'h00);
      @(negedge clk);
      bus.start = 1; bus.op = 4'd0; bus.reg1 = 0; bus.reg2 = 2;
      bus.num_words = 0; bus.ext_arg2 = 0;
      @(posedge clk); #1;
      bus.op = 4'd2; bus.reg1 = 1; bus.reg2 = 3;
      hs = 1; d = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         d[2*i +: 2] = bus.data_out;
         if (!(bus.data_valid === 1'b1 && bus.ready === (i % 4 == 3)
               && bus.digit_idx === 4'(i % 4))) hs = 0;
         @(posedge clk); #1;
         if (i == 3) bus.start = 0;
      end
      chk("b2b_hs", 32'(hs), 32'd1);
      chk("b2b_out", d, 32'h0100);
      chk("b2b_flags", 32'(fl()), 32'h0);
      rd(0, 2'd1, d);
      chk("b2b_regs", d, 32'h0100);

      // wrap-around dest r7 -> r0, start pulsed while busy
      ld(7, 8'hFF); ld(0, 8'h00); ld(3, 8'hA5);
      @(negedge clk);
      bus.start = 1; bus.op = 4'd0; bus.reg1 = 7; bus.reg2 = 0;
      bus.num_words = 1; bus.ext_arg2 = 1; bus.data_in = 2'b01;
      @(posedge clk); #1;
      bus.start = 0;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         bus.data_in = (i == 0) ? 2'b01 : 2'b00;
         if (i == 2) begin
            bus.start = 1; bus.op = 4'd7; bus.reg1 = 3;
         end
         @(negedge clk);
         if (i == 2) chk("wrap_busy_ready", 32'(bus.ready), 32'd0);
         d[2*i +: 2] = bus.data_out;
         @(posedge clk); #1;
         bus.start = 0;
      end
      chk("wrap_out", d, 32'h0100);
      @(negedge clk);
      chk("wrap_idle", 32'({bus.data_valid, bus.ready}), 32'b01);
      rd(7, 2'd1, d);
      chk("wrap_regs", d, 32'h0100);
      rd(3, 2'd0, d);
      chk("wrap_ignored", d, 32'hA5);

      // reset mid-op at counter 5 of a 16-cycle op
      ld(4, 8'h33); ld(0, 8'h80);
      chk("pre_rst_s", 32'(bus.flag_s), 32'd1);
      @(negedge clk);
      bus.start = 1; bus.op = 4'd0; bus.reg1 = 0; bus.reg2 = 4;
      bus.num_words = 3; bus.ext_arg2 = 0;
      @(posedge clk); #1;
      bus.start = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 5) begin
            chk("mid_idx", 32'(bus.digit_idx), 32'd5);
            reset_n = 1'b0;
            #1;
            chk("mid_ready", 32'(bus.ready), 32'd1);
            chk("mid_flags", 32'(fl()), 32'h0);
            chk("mid_valid", 32'({bus.data_valid, bus.done}), 32'd0);
            chk("mid_cnt", 32'(bus.digit_idx), 32'd0);
         end else begin
            @(posedge clk); #1;
         end
      end
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      rd(0, 2'd3, d);
      chk("mid_regs_lo", d, 32'h0);
      rd(4, 2'd3, d);
      chk("mid_regs_hi", d, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
